// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//
// Purpose:
//   Round-robin arbiter that lets N_REQ requesters share one WIDTH-bit
//   storage register (Input/Load/Clk). One requester at a time is granted,
//   its data is presented to the register with a one-cycle Load strobe, and
//   the winner receives a one-cycle Ack when the write has completed.
//
//   Transaction shape (one write every four cycles at full load):
//     IDLE  -> pick a winner, raise Gnt
//     GRANT -> winner still requesting: latch data, raise Load
//              winner gave up:         drop Gnt, back to IDLE (abort)
//     LOAD  -> register captures Load_Data, drop Load/Gnt, raise Ack,
//              record the winner as Owner and as the new round-robin pointer
//     ACK   -> drop Ack, back to IDLE
//
// Ports:
//   Clk          in   clock, rising edge
//   Reset_n      in   asynchronous active-low reset
//   Req          in   per-requester level write request
//   Data_In      in   packed request data, requester i at [i*WIDTH +: WIDTH]
//   Gnt          out  one-hot grant (GRANT and LOAD states)
//   Ack          out  one-hot, one-cycle completion pulse (ACK state)
//   Load         out  register load strobe, one cycle per write
//   Load_Data    out  data to the register Input, valid while Load=1
//   Owner        out  index of the last requester whose write completed
//   Busy         out  high whenever the FSM is not in IDLE
//   Write_Count  out  completed writes, wraps modulo 256

module reg_write_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic [N_REQ-1:0]       Req,
    input  logic [N_REQ*WIDTH-1:0] Data_In,
    output logic [N_REQ-1:0]       Gnt,
    output logic [N_REQ-1:0]       Ack,
    output logic                   Load,
    output logic [WIDTH-1:0]       Load_Data,
    output logic [IDX_W-1:0]       Owner,
    output logic                   Busy,
    output logic [7:0]             Write_Count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        LOAD  = 2'd2,
        ACK   = 2'd3
    } state_t;

    // Pointer reset value: the scan starts at Ptr+1, so resetting to the
    // last index gives requester 0 first priority.
    localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(N_REQ - 1);

    state_t                 state_q,      state_d;
    logic [IDX_W-1:0]       ptr_q,        ptr_d;
    logic [IDX_W-1:0]       winner_q,     winner_d;
    logic [N_REQ-1:0]       gnt_q,        gnt_d;
    logic [N_REQ-1:0]       ack_q,        ack_d;
    logic                   load_q,       load_d;
    logic [WIDTH-1:0]       loadData_q,   loadData_d;
    logic [IDX_W-1:0]       owner_q,      owner_d;
    logic [7:0]             writeCount_q, writeCount_d;

    logic                   selFound;
    logic [IDX_W-1:0]       selIdx;
    logic [WIDTH-1:0]       winnerData;
    logic                   winnerReq;

    // One-hot encoding of a requester index.
    function automatic logic [N_REQ-1:0] oneHot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] vec;
        vec = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (idx == IDX_W'(i)) begin
                vec[i] = 1'b1;
            end
        end
        return vec;
    endfunction

    // Round-robin winner search: scan Ptr+1, Ptr+2, ... modulo N_REQ and
    // keep the first requester found. Offset N_REQ lands back on Ptr itself,
    // so the previous owner is only chosen when nobody else is asking.
    always_comb begin
        int cand;
        selFound = 1'b0;
        selIdx   = '0;
        cand     = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = (int'(ptr_q) + off) % N_REQ;
            if (!selFound && Req[cand]) begin
                selFound = 1'b1;
                selIdx   = IDX_W'(cand);
            end
        end
    end

    // Request level and data slice of the currently granted requester.
    // A mux over all requesters keeps the index in range for any N_REQ.
    always_comb begin
        winnerReq  = 1'b0;
        winnerData = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner_q == IDX_W'(i)) begin
                winnerReq  = Req[i];
                winnerData = Data_In[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and output logic. Every register holds its value unless a
    // state explicitly changes it; non-winner Req changes are only looked at
    // in IDLE, so they are ignored for the rest of a transaction.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        winner_d     = winner_q;
        gnt_d        = gnt_q;
        ack_d        = ack_q;
        load_d       = load_q;
        loadData_d   = loadData_q;
        owner_d      = owner_q;
        writeCount_d = writeCount_q;

        case (state_q)
            IDLE: begin
                if (selFound) begin
                    winner_d = selIdx;
                    gnt_d    = oneHot(selIdx);
                    state_d  = GRANT;
                end
            end

            GRANT: begin
                if (winnerReq) begin
                    loadData_d = winnerData;
                    load_d     = 1'b1;
                    state_d    = LOAD;
                end else begin
                    // Winner withdrew: abandon the grant without touching
                    // the pointer so the rotation is not disturbed.
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end

            LOAD: begin
                load_d       = 1'b0;
                gnt_d        = '0;
                ack_d        = oneHot(winner_q);
                ptr_d        = winner_q;
                owner_d      = winner_q;
                writeCount_d = writeCount_q + 8'd1;
                state_d      = ACK;
            end

            ACK: begin
                ack_d   = '0;
                state_d = IDLE;
            end

            default: begin
                gnt_d   = '0;
                ack_d   = '0;
                load_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset is asynchronous so a pending Load is withdrawn
    // immediately and the half-finished write never gets an Ack.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            ptr_q        <= PTR_RESET;
            winner_q     <= '0;
            gnt_q        <= '0;
            ack_q        <= '0;
            load_q       <= 1'b0;
            loadData_q   <= '0;
            owner_q      <= '0;
            writeCount_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            winner_q     <= winner_d;
            gnt_q        <= gnt_d;
            ack_q        <= ack_d;
            load_q       <= load_d;
            loadData_q   <= loadData_d;
            owner_q      <= owner_d;
            writeCount_q <= writeCount_d;
        end
    end

    assign Gnt         = gnt_q;
    assign Ack         = ack_q;
    assign Load        = load_q;
    assign Load_Data   = loadData_q;
    assign Owner       = owner_q;
    assign Busy        = (state_q != IDLE);
    assign Write_Count = writeCount_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter
//
// Purpose:
//   Self-checking bench for reg_write_arbiter (4 requesters, 4-bit data).
//   Each requester is driven by a small agent: it raises Req with its next
//   data value, drops Req when it sees its Ack, and re-requests while it has
//   writes left. The expected grant order is pushed to a scoreboard queue
//   when a scenario is set up; every Load pops one entry and every Ack is
//   checked against it. A behavioural 4-bit register captures Load_Data.

module tb_reg_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int IW = 2;

    logic            Clk = 1'b0;
    logic            Reset_n;
    logic [N-1:0]    Req;
    logic [N*W-1:0]  Data_In;
    logic [N-1:0]    Gnt;
    logic [N-1:0]    Ack;
    logic            Load;
    logic [W-1:0]    Load_Data;
    logic [IW-1:0]   Owner;
    logic            Busy;
    logic [7:0]      Write_Count;

    typedef struct {
        int         idx;
        logic [3:0] data;
        int         count;
    } expT;

    expT        sbQ[$];
    expT        cur;
    bit         haveCur;
    bit         monitorOn;
    int         expCount;
    int         checkCount;
    int         errorCount;

    int         remaining[N];
    logic [3:0] dataBase[N];
    int         written[N];

    logic [3:0] regOut;

    reg_write_arbiter #(.N_REQ(N), .WIDTH(W), .IDX_W(IW)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Req         (Req),
        .Data_In     (Data_In),
        .Gnt         (Gnt),
        .Ack         (Ack),
        .Load        (Load),
        .Load_Data   (Load_Data),
        .Owner       (Owner),
        .Busy        (Busy),
        .Write_Count (Write_Count)
    );

    always #5 Clk = ~Clk;

    // Stand-in for the shared storage register.
    always @(posedge Clk) begin
        if (Load) begin
            regOut <= Load_Data;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] hot(input int idx);
        logic [31:0] v;
        v = 32'd0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic pushExp(input int idx, input logic [3:0] data);
        expT e;
        expCount   = expCount + 1;
        e.idx      = idx;
        e.data     = data;
        e.count    = expCount % 256;
        sbQ.push_back(e);
    endtask

    task automatic setupReq(input int idx, input int n, input logic [3:0] base);
        remaining[idx] = n;
        dataBase[idx]  = base;
        written[idx]   = 0;
    endtask

    // One clock: sample at the falling edge, score outputs, then let the
    // requester agents react.
    task automatic applyStimulus();
        @(negedge Clk);
        checkOutput("gntAckExcl", 32'(Gnt & Ack), 32'd0);
        if (monitorOn && Load) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpectedLoad", 32'd1, 32'd0);
            end else begin
                cur     = sbQ.pop_front();
                haveCur = 1'b1;
                checkOutput("loadData", 32'(Load_Data), 32'(cur.data));
                checkOutput("gntAtLoad", 32'(Gnt), hot(cur.idx));
            end
        end
        if (monitorOn && Ack != '0) begin
            if (!haveCur) begin
                checkOutput("unexpectedAck", 32'(Ack), 32'd0);
            end else begin
                checkOutput("ack", 32'(Ack), hot(cur.idx));
                checkOutput("owner", 32'(Owner), 32'(cur.idx));
                checkOutput("writeCount", 32'(Write_Count), 32'(cur.count));
                haveCur = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (Ack[i]) begin
                Req[i] = 1'b0;
                if (remaining[i] > 0) begin
                    remaining[i]--;
                    written[i]++;
                end
            end else if (!Req[i] && remaining[i] > 0) begin
                Req[i] = 1'b1;
                Data_In[i*W +: W] = dataBase[i] + 4'(written[i]);
            end
        end
    endtask

    function automatic bit agentsActive();
        bit a;
        a = (Req != '0);
        for (int i = 0; i < N; i++) begin
            if (remaining[i] > 0) a = 1'b1;
        end
        return a;
    endfunction

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while ((sbQ.size() != 0 || agentsActive() || Busy) && n < budget) begin
            applyStimulus();
            n++;
        end
        if (n >= budget) begin
            checkOutput("timeout", 32'd1, 32'd0);
        end
    endtask

    initial begin
        bit seenLoad;
        checkCount = 0;
        errorCount = 0;
        expCount   = 0;
        haveCur    = 1'b0;
        monitorOn  = 1'b1;
        Reset_n    = 1'b0;
        Req        = '0;
        Data_In    = '0;
        for (int i = 0; i < N; i++) setupReq(i, 0, 4'h0);

        // Reset held with every requester asking, then fairness 0,1,2,3.
        for (int i = 0; i < N; i++) setupReq(i, 1, 4'(i + 5));
        repeat (3) applyStimulus();
        checkOutput("resetGnt", 32'(Gnt), 32'd0);
        checkOutput("resetAck", 32'(Ack), 32'd0);
        checkOutput("resetLoad", 32'(Load), 32'd0);
        checkOutput("resetLoadData", 32'(Load_Data), 32'd0);
        checkOutput("resetOwner", 32'(Owner), 32'd0);
        checkOutput("resetBusy", 32'(Busy), 32'd0);
        checkOutput("resetCount", 32'(Write_Count), 32'd0);
        for (int i = 0; i < N; i++) pushExp(i, 4'(i + 5));
        Reset_n = 1'b1;
        applyStimulus();
        checkOutput("gntAfterReset", 32'(Gnt), 32'h1);
        checkOutput("busyInGrant", 32'(Busy), 32'd1);
        waitDone(200);

        // Scan wraps past 3 back to 0.
        setupReq(0, 1, 4'h1);
        setupReq(3, 1, 4'h9);
        pushExp(0, 4'h1);
        pushExp(3, 4'h9);
        waitDone(200);

        // Abort: requester 1 withdraws during GRANT; pointer must stay at 3.
        Req[1] = 1'b1;
        Data_In[1*W +: W] = 4'hE;
        applyStimulus();
        checkOutput("abortGnt", 32'(Gnt), 32'h2);
        Req[1] = 1'b0;
        applyStimulus();
        checkOutput("abortGntCleared", 32'(Gnt), 32'd0);
        checkOutput("abortIdle", 32'(Busy), 32'd0);
        checkOutput("abortNoLoad", 32'(Load), 32'd0);
        repeat (2) applyStimulus();
        checkOutput("abortNoAck", 32'(Ack), 32'd0);
        checkOutput("abortCount", 32'(Write_Count), 32'd6);
        setupReq(1, 1, 4'h2);
        setupReq(2, 1, 4'h7);
        pushExp(1, 4'h2);
        pushExp(2, 4'h7);
        waitDone(200);

        // Single write into the shared register.
        setupReq(2, 1, 4'hA);
        pushExp(2, 4'hA);
        waitDone(200);
        checkOutput("regOutput", 32'(regOut), 32'hA);

        // Starvation: 0 and 1 keep re-requesting, grants alternate.
        setupReq(0, 2, 4'h3);
        setupReq(1, 2, 4'hC);
        pushExp(0, 4'h3);
        pushExp(1, 4'hC);
        pushExp(0, 4'h4);
        pushExp(1, 4'hD);
        waitDone(200);

        // Reset in the LOAD cycle drops Load at once and clears the count.
        monitorOn = 1'b0;
        setupReq(3, 1, 4'hF);
        seenLoad = 1'b0;
        for (int n = 0; n < 10 && !seenLoad; n++) begin
            applyStimulus();
            seenLoad = Load;
        end
        checkOutput("midLoadSeen", 32'(seenLoad), 32'd1);
        Reset_n = 1'b0;
        #1;
        checkOutput("midLoad", 32'(Load), 32'd0);
        checkOutput("midCount", 32'(Write_Count), 32'd0);
        checkOutput("midGnt", 32'(Gnt), 32'd0);
        checkOutput("midBusy", 32'(Busy), 32'd0);
        checkOutput("midLoadData", 32'(Load_Data), 32'd0);
        for (int i = 0; i < N; i++) setupReq(i, 0, 4'h0);
        Req = '0;
        repeat (2) applyStimulus();
        Reset_n = 1'b1;
        repeat (3) applyStimulus();
        checkOutput("midNoAck", 32'(Ack), 32'd0);
        checkOutput("midCountAfter", 32'(Write_Count), 32'd0);
        expCount  = 0;
        haveCur   = 1'b0;
        monitorOn = 1'b1;

        // 256 writes: count reads 255 and then wraps to 0.
        setupReq(0, 256, 4'h0);
        for (int k = 0; k < 256; k++) pushExp(0, 4'(k));
        waitDone(2000);
        checkOutput("wrapFinal", 32'(Write_Count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
